// File: rtl/wb_load_unit.sv
// Writeback stage: selects ALU / AUIPC / JUMP / memory-load results and writes them to the register file.
// Optional misaligned-load trap is enabled with the WB_MISALIGN_TRAP_EN macro.
module wb_load_unit #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 1,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_src,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]    in_alu,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [1:0]         in_size,
    input  logic               in_unsigned,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [XLEN-1:0]    mem_addr,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata
`ifdef WB_MISALIGN_TRAP_EN
    ,
    output logic               misaligned
`endif
);

    localparam int OFF_W = $clog2(XLEN / 8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALU   = 2'd0,
        SRC_MEM   = 2'd1,
        SRC_AUIPC = 2'd2,
        SRC_JUMP  = 2'd3
    } src_t;

    state_t             state;
    logic [RADDR_W-1:0] lat_rd;
    logic [OFF_W-1:0]   lat_off;
    logic [1:0]         lat_size;
    logic               lat_unsigned;

    logic [1:0]         eff_size;
    logic [OFF_W-1:0]   align_mask;
    logic [OFF_W-1:0]   off_aligned;
    logic [XLEN-1:0]    direct_result;
`ifdef WB_MISALIGN_TRAP_EN
    logic               mis_req;
`endif

    // Shift the addressed field down to bit 0, then extend from the field's own MSB.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] rdata,
                                                input logic [OFF_W-1:0] off,
                                                input logic [1:0]       size,
                                                input logic             uns);
        logic [XLEN-1:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (size)
            2'd0:    return uns ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'd1:    return uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'd2:    return uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: return shifted;
        endcase
    endfunction

    always_comb begin
        eff_size = in_size;
        if (XLEN == 32 && in_size == 2'd3) begin
            eff_size = 2'd2;
        end
        align_mask  = {OFF_W{1'b1}} << eff_size;
        off_aligned = in_alu[OFF_W-1:0] & align_mask;
        case (src_t'(in_src))
            SRC_AUIPC: direct_result = in_pc + in_imm;
            SRC_JUMP:  direct_result = in_pc + XLEN'(PC_STEP);
            default:   direct_result = in_alu;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    assign mis_req = (in_alu[OFF_W-1:0] & ~align_mask) != '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            lat_rd        <= '0;
            lat_off       <= '0;
            lat_size      <= '0;
            lat_unsigned  <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            misaligned    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready     <= 1'b0;
                        lat_rd       <= in_rd;
                        lat_off      <= off_aligned;
                        lat_size     <= eff_size;
                        lat_unsigned <= in_unsigned;
                        if (in_src == SRC_MEM) begin
`ifdef WB_MISALIGN_TRAP_EN
                            if (mis_req) begin
                                state      <= WRITE;
                                misaligned <= 1'b1;
                            end else begin
`else
                            begin
`endif
                                state         <= REQ;
                                mem_req_valid <= 1'b1;
                                mem_addr      <= {in_alu[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            end
                        end else begin
                            state <= WRITE;
                            // rd=0 keeps the write port and its held values untouched.
                            if (in_rd != '0) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= in_rd;
                                rf_wdata <= direct_result;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= WRITE;
                        if (lat_rd != '0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= lat_rd;
                            rf_wdata <= extract(mem_rdata, lat_off, lat_size, lat_unsigned);
                        end
                    end
                end
                WRITE: begin
                    rf_we    <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
`ifdef WB_MISALIGN_TRAP_EN
                    misaligned <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_load_unit.sv
// Directed self-checking bench for wb_load_unit (XLEN=32); covers the trap path when WB_MISALIGN_TRAP_EN is defined.
module tb_wb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_src;
    logic [4:0]  in_rd;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wb_load_unit #(.XLEN(32), .PC_STEP(1), .RADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_src        (in_src),
        .in_rd         (in_rd),
        .in_alu        (in_alu),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .in_size       (in_size),
        .in_unsigned   (in_unsigned),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
`ifdef WB_MISALIGN_TRAP_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [1:0] size, input logic uns);
        in_src      = src;
        in_rd       = rd;
        in_alu      = alu;
        in_pc       = pc;
        in_imm      = imm;
        in_size     = size;
        in_unsigned = uns;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic direct_op(input string tag, input logic [1:0] src, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] exp);
        issue(src, rd, alu, pc, imm, 2'd2, 1'b0);
        check({tag, " we"}, rf_we, 1'b1);
        check({tag, " waddr"}, rf_waddr, rd);
        check({tag, " wdata"}, rf_wdata, exp);
        check({tag, " ready_low"}, in_ready, 1'b0);
        tick();
        check({tag, " we_drop"}, rf_we, 1'b0);
        check({tag, " ready_back"}, in_ready, 1'b1);
    endtask

    // Zero-wait memory load: accept, request accepted, response next cycle.
    task automatic load(input string tag, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic exp_we, input logic [31:0] exp_data);
        issue(2'd1, rd, alu, 32'h0, 32'h0, size, uns);
        check({tag, " req_valid"}, mem_req_valid, 1'b1);
        check({tag, " addr"}, mem_addr, exp_addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check({tag, " req_drop"}, mem_req_valid, 1'b0);
        check({tag, " no_early_we"}, rf_we, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check({tag, " we"}, rf_we, exp_we);
        check({tag, " wdata"}, rf_wdata, exp_data);
        tick();
        check({tag, " we_drop"}, rf_we, 1'b0);
        check({tag, " ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int unsigned we_count;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_src        = 2'd0;
        in_rd         = 5'd0;
        in_alu        = 32'h0;
        in_pc         = 32'h0;
        in_imm        = 32'h0;
        in_size       = 2'd0;
        in_unsigned   = 1'b0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset req_valid", mem_req_valid, 1'b0);
        check("reset rf_we", rf_we, 1'b0);
        check("reset waddr", rf_waddr, 5'd0);
        check("reset wdata", rf_wdata, 32'h0);
        check("reset addr", mem_addr, 32'h0);

        direct_op("alu",   2'd0, 5'd5, 32'h0000_1234, 32'h0,  32'h0,         32'h0000_1234);
        direct_op("auipc", 2'd2, 5'd1, 32'hDEAD_BEEF, 32'h10, 32'hFFFF_FFF0, 32'h0000_0000);
        direct_op("jump",  2'd3, 5'd2, 32'hDEAD_BEEF, 32'h10, 32'h0,         32'h0000_0011);
        direct_op("jwrap", 2'd3, 5'd3, 32'h0,         32'hFFFF_FFFF, 32'h0,  32'h0000_0000);

        load("lb",     5'd6, 32'h103, 2'd0, 1'b0, 32'h80FF_7F01, 32'h100, 1'b1, 32'hFFFF_FF80);
        load("lbu",    5'd6, 32'h103, 2'd0, 1'b1, 32'h80FF_7F01, 32'h100, 1'b1, 32'h0000_0080);
        load("lb_o1",  5'd7, 32'h201, 2'd0, 1'b0, 32'hDEAD_BEEF, 32'h200, 1'b1, 32'hFFFF_FFBE);
        load("lbu_o1", 5'd7, 32'h201, 2'd0, 1'b1, 32'hDEAD_BEEF, 32'h200, 1'b1, 32'h0000_00BE);
        load("lh_o2",  5'd8, 32'h302, 2'd1, 1'b0, 32'h7FFF_0000, 32'h300, 1'b1, 32'h0000_7FFF);
        load("lh_o0",  5'd8, 32'h300, 2'd1, 1'b0, 32'h1234_8001, 32'h300, 1'b1, 32'hFFFF_8001);
        load("lhu_o0", 5'd8, 32'h300, 2'd1, 1'b1, 32'h1234_8001, 32'h300, 1'b1, 32'h0000_8001);
        load("lw_uns", 5'd9, 32'h404, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'h404, 1'b1, 32'hDEAD_BEEF);
        load("ld_as_w",5'd9, 32'h408, 2'd3, 1'b0, 32'h8765_4321, 32'h408, 1'b1, 32'h8765_4321);
        // rd=0: full handshake, no write, write data holds previous value.
        load("rd0",    5'd0, 32'h500, 2'd2, 1'b0, 32'h1111_2222, 32'h500, 1'b0, 32'h8765_4321);

        // Stalled memory: stray rvalid during REQ must be ignored.
        we_count = 0;
        issue(2'd1, 5'd10, 32'h0000_0A06, 32'h0, 32'h0, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = (i == 1);
            mem_rdata  = 32'hFFFF_FFFF;
            check("stall req_valid", mem_req_valid, 1'b1);
            check("stall addr", mem_addr, 32'h0000_0A04);
            check("stall in_ready", in_ready, 1'b0);
            tick();
            if (rf_we) we_count++;
        end
        mem_rvalid    = 1'b0;
        mem_req_ready = 1'b1;
        check("stall addr_at_ready", mem_addr, 32'h0000_0A04);
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stall wait_in_ready", in_ready, 1'b0);
            check("stall wait_no_we", rf_we, 1'b0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hC0DE_0000;
        tick();
        mem_rvalid = 1'b0;
        check("stall we", rf_we, 1'b1);
        check("stall waddr", rf_waddr, 5'd10);
        check("stall wdata", rf_wdata, 32'hFFFF_C0DE);
        check("stall in_ready_at_we", in_ready, 1'b0);
        we_count++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rf_we) we_count++;
        end
        check("stall in_ready_after", in_ready, 1'b1);
        check("stall we_count", we_count, 1);

        // Reset while waiting for the response, then a late response.
        issue(2'd1, 5'd11, 32'h0000_0600, 32'h0, 32'h0, 2'd2, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_wait in_ready", in_ready, 1'b1);
        check("rst_wait req_valid", mem_req_valid, 1'b0);
        check("rst_wait addr", mem_addr, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        check("rst_wait stray_we", rf_we, 1'b0);
        tick();
        check("rst_wait stray_we2", rf_we, 1'b0);
        check("rst_wait wdata", rf_wdata, 32'h0);

`ifdef WB_MISALIGN_TRAP_EN
        issue(2'd1, 5'd12, 32'h0000_0701, 32'h0, 32'h0, 2'd1, 1'b0);
        check("trap pulse", misaligned, 1'b1);
        check("trap no_req", mem_req_valid, 1'b0);
        check("trap no_we", rf_we, 1'b0);
        tick();
        check("trap pulse_end", misaligned, 1'b0);
        check("trap no_req2", mem_req_valid, 1'b0);
        check("trap ready_back", in_ready, 1'b1);
`else
        // Half load at odd offset rounds down to bytes 0-1.
        load("lh_o1", 5'd12, 32'h701, 2'd1, 1'b0, 32'h80FF_7F01, 32'h700, 1'b1, 32'h0000_7F01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_load_unit.md
# wb_load_unit

Parametrised writeback stage between execute and the register file. Accepts one writeback request per handshake and selects the result source: ALU, PC+imm (auipc), PC+step (jump link) or data memory. For memory sources it runs the load request/response handshake, then extracts, aligns and sign/zero-extends the byte, halfword or word. Results are written to the register file through a registered one-cycle write port.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- PC_STEP, 1: link increment added to pc for jumps; 1 for word-addressed PC.
- RADDR_W, 5: register index width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  in  1  writeback request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_src  in  2  source: 0 ALU, 1 MEM, 2 AUIPC, 3 JUMP.
- in_rd  in  RADDR_W  destination register.
- in_alu  in  XLEN  ALU result; the load byte address when in_src=MEM.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  immediate, signed.
- in_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
- in_unsigned  in  1  zero-extend the loaded field.
- mem_req_valid  out  1  load request to data memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  XLEN  in_alu with low log2(XLEN/8) bits cleared.
- mem_rvalid  in  1  response data valid.
- mem_rdata  in  XLEN  aligned memory word.
- rf_we  out  1  register-file write strobe, one cycle.
- rf_waddr  out  RADDR_W  write index.
- rf_wdata  out  XLEN  write data.
- misaligned  out  1  one-cycle pulse; present only with the macro in Configuration.

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE: in_ready=1. On in_valid, latch all in_* fields.
  - in_src≠MEM: compute result and go to WRITE.
  - in_src=MEM: go to REQ.
- REQ: mem_req_valid=1; mem_addr held stable. Go to WAIT when mem_req_ready=1.
- WAIT: on mem_rvalid, capture mem_rdata and go to WRITE. mem_rvalid in any other state is ignored.
- WRITE: rf_we=1 for exactly one cycle, then return to IDLE. in_ready=0 in REQ, WAIT and WRITE.
- Result sources:
  - ALU: in_alu.
  - AUIPC: in_pc + in_imm, modulo 2^XLEN.
  - JUMP: in_pc + PC_STEP, modulo 2^XLEN.
- Load extraction:
  - Byte offset o = in_alu[log2(XLEN/8)-1:0]; field = mem_rdata >> (8·o), truncated to the size.
  - Sign extension uses the MSB of the selected field, not of the whole word.
  - in_unsigned=1 zero-extends. Word loads with XLEN=32 ignore in_unsigned.
  - in_size=3 with XLEN=32 is treated as a word load.
- rd=0: the FSM sequences normally, including the memory handshake, but rf_we stays 0.
- Reset: state IDLE. in_ready=1. mem_req_valid=0, mem_addr=0, rf_we=0, rf_waddr=0, rf_wdata=0, misaligned=0. Reset mid-transaction abandons the load; a late mem_rvalid after reset is ignored.

## Timing
- Non-memory request accepted in cycle N: rf_we=1 in cycle N+1. Sustained throughput is one request every 2 cycles.
- Memory request accepted in N: mem_req_valid=1 from N+1.
- mem_req_ready in cycle R: state is WAIT from R+1.
- mem_rvalid in cycle M (M ≥ R+1): rf_we=1 in M+1.
- Minimum load latency is 3 cycles from acceptance to rf_we, with a zero-wait memory.
- rf_waddr and rf_wdata are valid whenever rf_we=1 and hold their last values otherwise.

## Configuration
- WB_MISALIGN_TRAP_EN defined:
  - A MEM request is misaligned if half has odd o, word has o mod 4 ≠ 0, or dword has o ≠ 0.
  - On a misaligned request: go directly to WRITE with rf_we forced to 0, pulse misaligned=1 in N+1, and issue no memory request.
- Undefined: no misaligned port. Offset bits are rounded down to the size's alignment (o &= ~(size_bytes-1)) and the load proceeds.

## Test plan
- After reset: in_ready=1, mem_req_valid=0, rf_we=0.
- ALU src, rd=5, in_alu=0x1234 accepted in cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 in N+1.
- AUIPC src, pc=0x10, imm=0xFFFFFFF0 -> rf_wdata=0x0. JUMP src, pc=0x10 -> rf_wdata=0x11.
- MEM, signed byte, in_alu=0x103, mem_rdata=0x80FF7F01:
  - mem_addr=0x100 -> rf_wdata=0xFFFFFF80.
  - Same with in_unsigned=1 -> 0x00000080.
- MEM, signed half, o=2, mem_rdata=0x7FFF0000 -> 0x00007FFF.
- Memory stalls: mem_req_ready low for 3 cycles and mem_rvalid 2 cycles later -> mem_addr stable throughout, in_ready=0 until the cycle after rf_we, and exactly one rf_we.
- rd=0 load -> handshake completes and rf_we stays 0.
- rst_n low during WAIT, then a stray mem_rvalid -> no rf_we.
- With WB_MISALIGN_TRAP_EN, half load at o=1 -> misaligned pulse, no mem_req_valid, no rf_we.
- Without the macro, half load at o=1 reads bytes 0–1.
